// File: rtl/fsm_control_pkg.sv
// Shared constants for the transaction-layer control FSM.
// The word counters and the bench use the same state encodings and threshold defaults.
package fsm_control_pkg;

  localparam logic [4:0] ST_RESET  = 5'b00001;
  localparam logic [4:0] ST_INIT   = 5'b00010;
  localparam logic [4:0] ST_IDLE   = 5'b00100;
  localparam logic [4:0] ST_ACTIVE = 5'b01000;
  localparam logic [4:0] ST_ERROR  = 5'b10000;

  localparam int unsigned N_FIFO_DEF          = 4;
  localparam int unsigned W_UMBRAL_DEF        = 3;
  localparam int unsigned UMBRAL_ALTO_RST_DEF = 6;
  localparam int unsigned UMBRAL_BAJO_RST_DEF = 1;

  typedef enum logic [4:0] {
    StReset  = ST_RESET,
    StInit   = ST_INIT,
    StIdle   = ST_IDLE,
    StActive = ST_ACTIVE,
    StError  = ST_ERROR
  } state_e;

endpackage

// File: rtl/fsm_control.sv
// Main control FSM of the transaction layer: holds the FIFO thresholds,
// reports idle/active to the word counters and captures a sticky error vector.
module fsm_control
  import fsm_control_pkg::*;
#(
  parameter int unsigned N_FIFO          = N_FIFO_DEF,
  parameter int unsigned W_UMBRAL        = W_UMBRAL_DEF,
  parameter int unsigned UMBRAL_ALTO_RST = UMBRAL_ALTO_RST_DEF,
  parameter int unsigned UMBRAL_BAJO_RST = UMBRAL_BAJO_RST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [W_UMBRAL-1:0] umbral_alto,
  input  logic [W_UMBRAL-1:0] umbral_bajo,
  input  logic [N_FIFO-1:0]   fifo_empty,
  input  logic [N_FIFO-1:0]   fifo_error,
  output logic [W_UMBRAL-1:0] umbral_alto_out,
  output logic [W_UMBRAL-1:0] umbral_bajo_out,
  output logic [4:0]          state,
  output logic                idle,
  output logic                active,
  output logic [N_FIFO-1:0]   error_out,
  output logic                cfg_err
);

  localparam logic [W_UMBRAL-1:0] AltoRst = W_UMBRAL'(UMBRAL_ALTO_RST);
  localparam logic [W_UMBRAL-1:0] BajoRst = W_UMBRAL'(UMBRAL_BAJO_RST);

  state_e              state_q, state_d;
  logic [W_UMBRAL-1:0] alto_q, alto_d;
  logic [W_UMBRAL-1:0] bajo_q, bajo_d;
  logic [N_FIFO-1:0]   err_q, err_d;
  logic                cfg_err_q, cfg_err_d;
  logic                idle_q, idle_d;
  logic                active_q, active_d;
  // Set while INIT may still evaluate a load; cleared by a rejected load
  // so that only a fresh init pulse triggers the next attempt.
  logic                armed_q, armed_d;

  always_comb begin
    state_d   = state_q;
    alto_d    = alto_q;
    bajo_d    = bajo_q;
    err_d     = err_q;
    cfg_err_d = cfg_err_q;
    armed_d   = armed_q;
    unique case (state_q)
      StReset: begin
        state_d = StInit;
        armed_d = 1'b1;
      end
      StInit: begin
        if (init) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          if (umbral_bajo < umbral_alto) begin
            alto_d    = umbral_alto;
            bajo_d    = umbral_bajo;
            cfg_err_d = 1'b0;
            state_d   = StIdle;
          end else begin
            cfg_err_d = 1'b1;
            armed_d   = 1'b0;
          end
        end
      end
      StIdle, StActive: begin
        if (|fifo_error) begin
          state_d = StError;
          err_d   = fifo_error;
        end else if (init) begin
          state_d = StInit;
          armed_d = 1'b1;
        end else if (&fifo_empty) begin
          state_d = StIdle;
        end else begin
          state_d = StActive;
        end
      end
      StError: begin
        err_d = err_q | fifo_error;
      end
      default: state_d = StReset;
    endcase
    idle_d   = (state_d == StIdle);
    active_d = (state_d == StActive);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StReset;
      alto_q    <= AltoRst;
      bajo_q    <= BajoRst;
      err_q     <= '0;
      cfg_err_q <= 1'b0;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alto_q    <= alto_d;
      bajo_q    <= bajo_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_err_d;
      idle_q    <= idle_d;
      active_q  <= active_d;
      armed_q   <= armed_d;
    end
  end

  assign state           = state_q;
  assign umbral_alto_out = alto_q;
  assign umbral_bajo_out = bajo_q;
  assign error_out       = err_q;
  assign cfg_err         = cfg_err_q;
  assign idle            = idle_q;
  assign active          = active_q;

endmodule

// File: tb/tb_fsm_control.sv
// Bench for fsm_control: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the control rules.
module tb_fsm_control;
  import fsm_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] umbral_alto, umbral_bajo;
  logic [3:0] fifo_empty, fifo_error;
  logic [2:0] umbral_alto_out, umbral_bajo_out;
  logic [4:0] state;
  logic       idle, active, cfg_err;
  logic [3:0] error_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [4:0] m_state;
  int         m_alto, m_bajo;
  logic [3:0] m_err;
  logic       m_cfg;
  logic       m_may_load;

  fsm_control dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_alto     (umbral_alto),
    .umbral_bajo     (umbral_bajo),
    .fifo_empty      (fifo_empty),
    .fifo_error      (fifo_error),
    .umbral_alto_out (umbral_alto_out),
    .umbral_bajo_out (umbral_bajo_out),
    .state           (state),
    .idle            (idle),
    .active          (active),
    .error_out       (error_out),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state    = ST_RESET;
    m_alto     = UMBRAL_ALTO_RST_DEF;
    m_bajo     = UMBRAL_BAJO_RST_DEF;
    m_err      = '0;
    m_cfg      = 1'b0;
    m_may_load = 1'b0;
  endtask

  // One rising edge of the control rules, applied to the current inputs.
  task automatic model_edge();
    if (m_state == ST_RESET) begin
      m_state    = ST_INIT;
      m_may_load = 1'b1;
    end else if (m_state == ST_INIT) begin
      if (init) m_may_load = 1'b1;
      else if (m_may_load) begin
        if (int'(umbral_bajo) < int'(umbral_alto)) begin
          m_alto  = umbral_alto;
          m_bajo  = umbral_bajo;
          m_cfg   = 1'b0;
          m_state = ST_IDLE;
        end else begin
          m_cfg      = 1'b1;
          m_may_load = 1'b0;
        end
      end
    end else if (m_state == ST_ERROR) begin
      m_err = m_err | fifo_error;
    end else begin
      if (fifo_error != 0) begin
        m_state = ST_ERROR;
        m_err   = fifo_error;
      end else if (init) begin
        m_state    = ST_INIT;
        m_may_load = 1'b1;
      end else if (fifo_empty == 4'hF) m_state = ST_IDLE;
      else m_state = ST_ACTIVE;
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("idle", 32'(idle), 32'(m_state == ST_IDLE));
    check("active", 32'(active), 32'(m_state == ST_ACTIVE));
    check("error_out", 32'(error_out), 32'(m_err));
    check("cfg_err", 32'(cfg_err), 32'(m_cfg));
    check("alto", 32'(umbral_alto_out), 32'(m_alto));
    check("bajo", 32'(umbral_bajo_out), 32'(m_bajo));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    init        = 1'b0;
    umbral_alto = 3'd5;
    umbral_bajo = 3'd2;
    fifo_empty  = 4'hF;
    fifo_error  = 4'h0;
    model_reset();
    #3;
    check_all();
    check("rst_state", 32'(state), 32'(ST_RESET));
    @(negedge clk);
    reset = 1'b0;

    // Load 5/2 after two init cycles
    init = 1'b1;
    step();
    step();
    init = 1'b0;
    step();
    check("t1_state", 32'(state), 32'(ST_IDLE));
    check("t1_alto", 32'(umbral_alto_out), 32'd5);
    check("t1_bajo", 32'(umbral_bajo_out), 32'd2);
    check("t1_idle", 32'(idle), 32'd1);

    // Equal thresholds rejected, then a fresh pulse loads 4/1
    do_reset();
    umbral_alto = 3'd3;
    umbral_bajo = 3'd3;
    step();
    step();
    step();
    check("t2_state", 32'(state), 32'(ST_INIT));
    check("t2_cfg", 32'(cfg_err), 32'd1);
    check("t2_alto", 32'(umbral_alto_out), 32'd6);
    init = 1'b1;
    umbral_alto = 3'd4;
    umbral_bajo = 3'd1;
    step();
    init = 1'b0;
    step();
    check("t2_idle", 32'(state), 32'(ST_IDLE));
    check("t2_cfg_clr", 32'(cfg_err), 32'd0);
    check("t2_alto4", 32'(umbral_alto_out), 32'd4);

    // IDLE <-> ACTIVE
    fifo_empty = 4'b1011;
    step();
    check("t3_active", 32'(active), 32'd1);
    fifo_empty = 4'hF;
    step();
    check("t3_idle", 32'(idle), 32'd1);

    // Sticky error accumulation; init ignored in ERROR
    fifo_empty = 4'b1011;
    step();
    fifo_error = 4'b0100;
    step();
    check("t4_err1", 32'(error_out), 32'h4);
    fifo_error = 4'b0001;
    step();
    check("t4_err2", 32'(error_out), 32'h5);
    fifo_error = 4'b0000;
    init = 1'b1;
    step();
    step();
    check("t4_absorb", 32'(state), 32'(ST_ERROR));
    init = 1'b0;

    // Error beats init in IDLE
    do_reset();
    umbral_alto = 3'd5;
    umbral_bajo = 3'd2;
    fifo_empty  = 4'hF;
    step();
    step();
    fifo_error = 4'b0010;
    init = 1'b1;
    step();
    check("t5_state", 32'(state), 32'(ST_ERROR));
    check("t5_err", 32'(error_out), 32'h2);
    fifo_error = 4'b0000;
    init = 1'b0;

    // Reset while ACTIVE
    do_reset();
    step();
    step();
    fifo_empty = 4'b0111;
    step();
    do_reset();
    check("t6_state", 32'(state), 32'(ST_RESET));
    check("t6_alto", 32'(umbral_alto_out), 32'd6);
    step();
    check("t6_init", 32'(state), 32'(ST_INIT));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      init        = ($urandom_range(0, 7) == 0);
      umbral_alto = 3'($urandom);
      umbral_bajo = 3'($urandom);
      fifo_empty  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      fifo_error  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_control.md
Name: fsm_control

Overview:
Main control state machine of the transaction layer, directly upstream of the word counters. Watches the FIFO bank's empty and error flags and holds the FIFO almost-full/almost-empty thresholds. Produces the registered `idle` indication that the counters use to freeze and report their totals, plus the sticky error vector.

Parameters:
N_FIFO, 4, number of monitored FIFOs (virtual-channel FIFOs plus in/out FIFOs as instantiated)
W_UMBRAL, 3, threshold width; FIFO depth is 2**W_UMBRAL
UMBRAL_ALTO_RST, 6, almost-full threshold value after reset
UMBRAL_BAJO_RST, 1, almost-empty threshold value after reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  request to (re)load thresholds
umbral_alto  input  W_UMBRAL  almost-full threshold candidate
umbral_bajo  input  W_UMBRAL  almost-empty threshold candidate
fifo_empty  input  N_FIFO  per-FIFO empty flags
fifo_error  input  N_FIFO  per-FIFO overflow/underflow pulses
umbral_alto_out  output  W_UMBRAL  active almost-full threshold to FIFOs
umbral_bajo_out  output  W_UMBRAL  active almost-empty threshold to FIFOs
state  output  5  one-hot current state
idle  output  1  high exactly while in IDLE; to counters
active  output  1  high exactly while in ACTIVE
error_out  output  N_FIFO  sticky captured error vector
cfg_err  output  1  last threshold load rejected

Behaviour:
- States are one-hot: RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000.
- Reset asserted, at any time including mid-operation, takes effect immediately:
  - state=RESET; idle=0, active=0, error_out=0, cfg_err=0.
  - umbral_alto_out=UMBRAL_ALTO_RST, umbral_bajo_out=UMBRAL_BAJO_RST.
- All outputs are registered. `idle`, `active` and `error_out` change on the same edge as `state`.
- Transition priority per edge is: reset > error > init > empty flags.
- RESET: on the first edge after reset deasserts, go to INIT.
- INIT:
  - Each edge with init=1: stay in INIT.
  - First edge with init=0:
    - If umbral_bajo < umbral_alto: load both into the *_out registers, clear cfg_err, go to IDLE.
    - Otherwise: keep the old thresholds, set cfg_err=1, stay in INIT until init pulses again.
  - The comparison is unsigned and width W_UMBRAL.
  - Equal values are rejected.
- IDLE:
  - any fifo_error bit set -> ERROR.
  - else init=1 -> INIT.
  - else any fifo_empty bit =0 -> ACTIVE.
  - else stay.
- ACTIVE:
  - any fifo_error -> ERROR.
  - else init=1 -> INIT.
  - else fifo_empty all ones -> IDLE.
  - else stay.
- ERROR:
  - Entered from IDLE or ACTIVE only; fifo_error is ignored in RESET and INIT.
  - On entry, error_out <= fifo_error. While in ERROR, error_out |= fifo_error each edge.
  - ERROR is absorbing: init is ignored and the only exit is reset.
- Thresholds never change outside the INIT exit edge.
- Latency: every input-driven transition is visible one clock after the sampling edge.

Decomposition:
- Shared package holds:
  - the one-hot state localparams (ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR);
  - the default threshold constants.
  The counters and the bench use these same constants.
- No sub-module is needed. The block is one next-state combinational process plus one asynchronous-reset register process.

Test Plan:
- Reset, then init=1 for 2 cycles, init=0 with umbral_alto=5 and umbral_bajo=2 -> states RESET, INIT, INIT, IDLE; outputs alto=5, bajo=2, idle=1, cfg_err=0.
- In INIT, init=0 with alto=3, bajo=3 -> stays INIT, cfg_err=1, thresholds remain 6/1. Then an init pulse with 4/1 -> IDLE, thresholds 4/1, cfg_err=0.
- In IDLE, fifo_empty=4'b1011 -> ACTIVE next edge (idle=0, active=1). fifo_empty=4'b1111 -> IDLE next edge.
- In ACTIVE, fifo_error=4'b0100 for 1 cycle, then 4'b0001 -> ERROR with error_out=0100, then 0101. Asserting init changes nothing; state stays ERROR.
- Same cycle: fifo_error=4'b0010 and init=1 in IDLE -> ERROR (error priority).
- Reset asserted mid-cycle while in ACTIVE -> state=00001, idle=0, error_out=0, thresholds 6/1 immediately without a clock edge. Release -> INIT on next edge.
